alu_arbiter: RTL

- Shares one combinational ALU between two requesters (slot 0: EX stage, slot 1: address/branch helper) using round-robin arbitration.
- Requests and responses both use valid/ready handshakes.
- Latches the winner's operands, drives them to the ALU for a configurable number of settle cycles, then registers the result and holds it until the owner accepts it.

---
 rtl/alu_arbiter.sv | 112 +++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Operands are latched on accept, held for ALU_LATENCY+1 cycles, then the result is held until taken.
module alu_arbiter #(
  parameter int ALU_LATENCY = 0,
  parameter int WIDTH       = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             reqValid0,
  output logic             reqReady0,
  input  logic [3:0]       reqOperation0,
  input  logic [WIDTH-1:0] reqInputA0,
  input  logic [WIDTH-1:0] reqInputB0,
  input  logic             reqValid1,
  output logic             reqReady1,
  input  logic [3:0]       reqOperation1,
  input  logic [WIDTH-1:0] reqInputA1,
  input  logic [WIDTH-1:0] reqInputB1,
  output logic             respValid0,
  input  logic             respReady0,
  output logic [WIDTH-1:0] respResult0,
  output logic             respValid1,
  input  logic             respReady1,
  output logic [WIDTH-1:0] respResult1,
  output logic [WIDTH-1:0] aluInputA,
  output logic [WIDTH-1:0] aluInputB,
  output logic [3:0]       aluOperation,
  input  logic [WIDTH-1:0] aluOutput
);
  localparam logic [3:0] LAT = ALU_LATENCY[3:0];

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, result_q, result_d;
  logic [3:0]       opc_q, opc_d, cnt_q, cnt_d;
  logic             owner_q, owner_d, prio_q, prio_d;
  logic             gnt0, gnt1, resp_hs, slot_free, accept;

  // Tie goes to the slot named by prio_q; a lone requester always wins.
  assign gnt0 = reqValid0 & (~reqValid1 | ~prio_q);
  assign gnt1 = reqValid1 & (~reqValid0 | prio_q);

  assign resp_hs   = (state_q == RESP) & (owner_q ? respReady1 : respReady0);
  assign slot_free = ~reset & ((state_q == IDLE) | resp_hs);
  assign reqReady0 = gnt0 & slot_free;
  assign reqReady1 = gnt1 & slot_free;
  assign accept    = reqReady0 | reqReady1;

  assign respValid0  = ~reset & (state_q == RESP) & ~owner_q;
  assign respValid1  = ~reset & (state_q == RESP) & owner_q;
  assign respResult0 = ((state_q == RESP) && !owner_q) ? result_q : '0;
  assign respResult1 = ((state_q == RESP) && owner_q)  ? result_q : '0;

  assign aluInputA    = opa_q;
  assign aluInputB    = opb_q;
  assign aluOperation = opc_q;

  always_comb begin
    state_d  = state_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    opc_d    = opc_q;
    cnt_d    = cnt_q;
    owner_d  = owner_q;
    prio_d   = prio_q;
    result_d = result_q;
    case (state_q)
      EXEC: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAT) begin
          result_d = aluOutput;
          state_d  = RESP;
        end
      end
      RESP: if (resp_hs) state_d = IDLE;
      default: ;
    endcase
    // A new accept overrides the RESP->IDLE exit for back-to-back operation.
    if (accept) begin
      opa_d   = reqReady1 ? reqInputA1 : reqInputA0;
      opb_d   = reqReady1 ? reqInputB1 : reqInputB0;
      opc_d   = reqReady1 ? reqOperation1 : reqOperation0;
      owner_d = reqReady1;
      prio_d  = ~reqReady1;
      cnt_d   = '0;
      state_d = EXEC;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      opc_q    <= '0;
      cnt_q    <= '0;
      owner_q  <= 1'b0;
      prio_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      opc_q    <= opc_d;
      cnt_q    <= cnt_d;
      owner_q  <= owner_d;
      prio_q   <= prio_d;
      result_q <= result_d;
    end
  end
endmodule
